// File: rtl/prefetch_queue.sv
// Instruction prefetcher: owns the fetch PC, keeps a DEPTH-entry FIFO of {word, pc, error}
// and feeds the decoder. Optional statistics counters are enabled with `define PREFETCH_STATS_EN.
module prefetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] bus_address,
    output logic              bus_write,
    output logic              bus_start,
    input  logic              bus_available,
    input  logic              bus_ready,
    input  logic              bus_response,
    input  logic [DATA_W-1:0] bus_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_error
`ifdef PREFETCH_STATS_EN
    ,
    input  logic              stat_clear,
    output logic [31:0]       stat_fetches,
    output logic [31:0]       stat_stalls
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAITING = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic [ADDR_W-1:0] r_bus_address;
    logic              r_bus_start;
    logic              r_halted;
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];
    logic [DEPTH-1:0]  r_fifo_err;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_issue;
    logic              w_push;
    logic              w_push_err;
    logic              w_pop;
    logic              w_reply_done;
    logic              w_out_valid;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic              w_unused_pc_bits;

    assign w_redirect_pc    = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_unused_pc_bits = ^redirect_pc[1:0];

    // Next-state and handshake decode
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_push       = 1'b0;
        w_push_err   = 1'b0;
        w_reply_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!redirect && !r_halted && bus_available && bus_ready && (r_count < FULL_CNT)) begin
                    w_issue      = 1'b1;
                    w_next_state = ST_WAITING;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAITING: begin
                if (redirect) begin
                    if (bus_ready) begin
                        w_reply_done = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_DISCARD;
                    end
                end else if (bus_ready) begin
                    w_reply_done = 1'b1;
                    w_push       = 1'b1;
                    w_push_err   = bus_response;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_WAITING;
                end
            end
            ST_DISCARD: begin
                if (bus_ready) begin
                    w_reply_done = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DISCARD;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        w_out_valid = (r_count != {CNT_W{1'b0}});
        w_pop       = w_out_valid && out_ready && !redirect;
    end

    // State, bus request and fetch-PC registers
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state       <= ST_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= '0;
            r_bus_address <= '0;
            r_bus_start   <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_issue) begin
                r_bus_address <= r_fetch_pc;
                r_bus_start   <= 1'b1;
                r_req_pc      <= r_fetch_pc;
            end else if (w_reply_done) begin
                r_bus_start <= 1'b0;
            end
            if (redirect) begin
                r_fetch_pc <= w_redirect_pc;
                r_halted   <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                end
                if (w_push && w_push_err) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    // FIFO storage; a redirect wins over any push or pop in the same cycle
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fifo_err <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_push_err ? {DATA_W{1'b0}} : bus_read_data;
                r_fifo_pc[r_wr_ptr]   <= r_req_pc;
                r_fifo_err[r_wr_ptr]  <= w_push_err;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus_address = r_bus_address;
    assign bus_start   = r_bus_start;
    assign bus_write   = 1'b0;
    assign out_valid   = w_out_valid;
    assign out_data    = w_out_valid ? r_fifo_data[r_rd_ptr] : {DATA_W{1'b0}};
    assign out_pc      = w_out_valid ? r_fifo_pc[r_rd_ptr]   : {ADDR_W{1'b0}};
    assign out_error   = w_out_valid ? r_fifo_err[r_rd_ptr]  : 1'b0;

`ifdef PREFETCH_STATS_EN
    logic [31:0] r_stat_fetches;
    logic [31:0] r_stat_stalls;
    logic        w_stall;

    assign w_stall = (r_state == ST_IDLE) && !r_halted && (r_count == FULL_CNT);

    // Saturating statistics counters, clear beats increment
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_stat_fetches <= 32'd0;
            r_stat_stalls  <= 32'd0;
        end else if (stat_clear) begin
            r_stat_fetches <= 32'd0;
            r_stat_stalls  <= 32'd0;
        end else begin
            if (w_push && !w_push_err && (r_stat_fetches != 32'hFFFF_FFFF)) begin
                r_stat_fetches <= r_stat_fetches + 32'd1;
            end
            if (w_stall && (r_stat_stalls != 32'hFFFF_FFFF)) begin
                r_stat_stalls <= r_stat_stalls + 32'd1;
            end
        end
    end

    assign stat_fetches = r_stat_fetches;
    assign stat_stalls  = r_stat_stalls;
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Randomized bench for prefetch_queue against a queue-based reference model.
module tb_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        nreset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] bus_address;
    logic        bus_write;
    logic        bus_start;
    logic        bus_available;
    logic        bus_ready;
    logic        bus_response;
    logic [31:0] bus_read_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_pc;
    logic        out_error;
`ifdef PREFETCH_STATS_EN
    logic        stat_clear;
    logic [31:0] stat_fetches;
    logic [31:0] stat_stalls;
`endif

    always #5 clock = ~clock;

    prefetch_queue #(
        .DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .RESET_PC(RESET_PC)
    ) dut (
        .clock(clock), .nreset(nreset),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .bus_address(bus_address), .bus_write(bus_write), .bus_start(bus_start),
        .bus_available(bus_available), .bus_ready(bus_ready),
        .bus_response(bus_response), .bus_read_data(bus_read_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_pc(out_pc), .out_error(out_error)
`ifdef PREFETCH_STATS_EN
        ,
        .stat_clear(stat_clear), .stat_fetches(stat_fetches), .stat_stalls(stat_stalls)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic        err;
    } entry_t;

    // Reference model: decoded stream as a queue plus the one outstanding transfer
    entry_t      mq[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_addr;
    bit          m_busy;
    bit          m_stale;
    bit          m_halted;
    int          m_fetches;
    int          m_stalls;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fetch_pc = RESET_PC;
        m_addr     = 32'h0;
        m_busy     = 1'b0;
        m_stale    = 1'b0;
        m_halted   = 1'b0;
        m_fetches  = 0;
        m_stalls   = 0;
    endtask

    task automatic check_outputs();
        chk("bus_write", bus_write, 1'b0);
        chk("bus_start", bus_start, m_busy);
        chk("bus_address", bus_address, m_addr);
        chk("out_valid", out_valid, (mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_data", out_data, mq[0].data);
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_error", out_error, mq[0].err);
        end else begin
            chk("out_data_idle", out_data, 32'h0);
            chk("out_pc_idle", out_pc, 32'h0);
        end
`ifdef PREFETCH_STATS_EN
        chk("stat_fetches", stat_fetches, m_fetches);
        chk("stat_stalls", stat_stalls, m_stalls);
`endif
    endtask

    // One clock: drive inputs, advance the model, then check on the falling edge
    task automatic step(input bit rd, input logic [31:0] rpc, input bit avail, input bit rdy,
                        input bit resp, input bit ordy, input bit sclr);
        entry_t e;
        bit     do_push;
        bit     pop;
        bit     issue;
        bit     stall;
        redirect      = rd;
        redirect_pc   = rpc;
        bus_available = avail;
        bus_ready     = rdy;
        bus_response  = resp;
        bus_read_data = m_busy ? (m_addr ^ 32'hA5A5_A5A5) : 32'($urandom);
        out_ready     = ordy;
`ifdef PREFETCH_STATS_EN
        stat_clear    = sclr;
`endif
        do_push = 1'b0;
        pop     = (mq.size() != 0) && ordy && !rd;
        issue   = !m_busy && !rd && !m_halted && avail && rdy && (mq.size() < DEPTH);
        stall   = !m_busy && !m_halted && (mq.size() == DEPTH);
        if (m_busy) begin
            if (rdy) begin
                if (!m_stale && !rd) begin
                    do_push = 1'b1;
                    e.pc    = m_addr;
                    e.err   = resp;
                    e.data  = resp ? 32'h0 : (m_addr ^ 32'hA5A5_A5A5);
                end
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end else if (rd) begin
                m_stale = 1'b1;
            end
        end else if (issue) begin
            m_busy     = 1'b1;
            m_addr     = m_fetch_pc;
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (rd) begin
            mq.delete();
            m_fetch_pc = {rpc[31:2], 2'b00};
            m_halted   = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(e);
                if (e.err) m_halted = 1'b1;
            end
        end
        if (sclr) begin
            m_fetches = 0;
            m_stalls  = 0;
        end else begin
            if (do_push && !e.err) m_fetches++;
            if (stall) m_stalls++;
        end
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    initial begin
        nreset        = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        bus_available = 1'b0;
        bus_ready     = 1'b0;
        bus_response  = 1'b0;
        bus_read_data = 32'h0;
        out_ready     = 1'b0;
`ifdef PREFETCH_STATS_EN
        stat_clear    = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clock);
        check_outputs();
        nreset = 1'b1;

        // zero-wait stream from RESET_PC, decoder always ready
        repeat (20) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        // decoder stalled: fill to DEPTH, then no more requests
        repeat (16) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // drain while replies keep arriving (simultaneous push and pop)
        repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // redirect while WAITING with a delayed reply
        step(1'b1, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h2002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("redirect_head_pc", out_pc, 32'h2000);

        // error reply halts fetching until the next redirect
        step(1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("error_head_pc", out_pc, 32'h40);
        chk("error_head_flag", out_error, 1'b1);
        step(1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom & 32'h0000_0FFF),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 63) == 0));
        end

        // asynchronous reset in the middle of a transfer
        step(1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        nreset = 1'b0;
        #1;
        chk("reset_bus_start", bus_start, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        model_reset();
        @(negedge clock);
        check_outputs();
        nreset = 1'b1;
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
